// File: rtl/isp8_flags_if.sv
// Flag-unit bus for isp8_flags: ALU result/carry, flag set/clear strobes,
// interrupt save/restore pulses, branch condition and the registered flag outputs.
interface isp8_flags_if;
  logic [7:0] dout_alu;
  logic       cout_alu;
  logic       upd_c;
  logic       upd_z;
  logic       setc;
  logic       clrc;
  logic       setz;
  logic       clrz;
  logic       seti;
  logic       clri;
  logic       int_entry;
  logic       reti;
  logic [1:0] cond;
  logic       carry_flag;
  logic       zero_flag;
  logic       ie_flag;
  logic       cond_true;
  logic       save_ovf;
  logic       save_unf;
  logic [3:0] save_depth;

  // Core side: drives ALU results and control strobes, observes the flags.
  modport master (
    output dout_alu, cout_alu, upd_c, upd_z, setc, clrc, setz, clrz, seti, clri,
           int_entry, reti, cond,
    input  carry_flag, zero_flag, ie_flag, cond_true, save_ovf, save_unf, save_depth
  );

  // Flag unit side.
  modport slave (
    input  dout_alu, cout_alu, upd_c, upd_z, setc, clrc, setz, clrz, seti, clri,
           int_entry, reti, cond,
    output carry_flag, zero_flag, ie_flag, cond_true, save_ovf, save_unf, save_depth
  );
endinterface

// File: rtl/isp8_flags.sv
// isp8_flags: carry / zero / interrupt-enable flag register for the ISP8 core,
// with an interrupt save stack and branch-condition evaluation.
// Optional feature macro ISP8_FLAG_NEST_EN: when defined the save stack holds
// NEST_DEPTH entries; otherwise a single save register is used.
module isp8_flags #(
  parameter int unsigned NEST_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  isp8_flags_if.slave bus
);

`ifdef ISP8_FLAG_NEST_EN
  localparam int unsigned Depth = NEST_DEPTH;
`else
  // Single save register; NEST_DEPTH has no effect in this build.
  localparam int unsigned Depth = (NEST_DEPTH > 0) ? 1 : 1;
`endif

  logic       c_q, c_d;
  logic       z_q, z_d;
  logic       ie_q, ie_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic [3:0] depth_q, depth_d;
  logic [2:0] stack_q [Depth];
  logic [2:0] stack_d [Depth];

  logic       zero_cand;
  logic       full;
  logic       empty;
  logic [2:0] top;

  assign zero_cand = (bus.dout_alu == 8'h00);
  assign full      = (depth_q == 4'(Depth));
  assign empty     = (depth_q == 4'd0);

  // Most recently pushed entry; entries are stored as {ie, z, c}.
  always_comb begin
    top = 3'b000;
    for (int i = 0; i < Depth; i++) begin
      if (4'(i + 1) == depth_q) top = stack_q[i];
    end
  end

  // Next-state: interrupt entry > return > set/clear > ALU update > hold.
  always_comb begin
    c_d     = c_q;
    z_d     = z_q;
    ie_d    = ie_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    depth_d = depth_q;
    stack_d = stack_q;

    if (bus.int_entry) begin
      // A simultaneous reti is dropped; ie is cleared even on overflow.
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < Depth; i++) begin
          if (4'(i) == depth_q) stack_d[i] = {ie_q, z_q, c_q};
        end
        depth_d = depth_q + 4'd1;
      end
      ie_d = 1'b0;
    end else if (bus.reti) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        {ie_d, z_d, c_d} = top;
        depth_d = depth_q - 4'd1;
      end
    end else begin
      // Each flag resolves independently: set beats clear, both beat ALU update.
      if (bus.setc)       c_d = 1'b1;
      else if (bus.clrc)  c_d = 1'b0;
      else if (bus.upd_c) c_d = bus.cout_alu;

      if (bus.setz)       z_d = 1'b1;
      else if (bus.clrz)  z_d = 1'b0;
      else if (bus.upd_z) z_d = zero_cand;

      if (bus.seti)       ie_d = 1'b1;
      else if (bus.clri)  ie_d = 1'b0;
    end
  end

  // State register with asynchronous clear of flags, sticky errors and stack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      depth_q <= 4'd0;
      stack_q <= '{default: 3'b000};
    end else begin
      c_q     <= c_d;
      z_q     <= z_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      depth_q <= depth_d;
      stack_q <= stack_d;
    end
  end

  // Branch condition from the registered flags only.
  always_comb begin
    unique case (bus.cond)
      2'b00:   bus.cond_true = z_q;
      2'b01:   bus.cond_true = ~z_q;
      2'b10:   bus.cond_true = c_q;
      default: bus.cond_true = ~c_q;
    endcase
  end

  assign bus.carry_flag = c_q;
  assign bus.zero_flag  = z_q;
  assign bus.ie_flag    = ie_q;
  assign bus.save_ovf   = ovf_q;
  assign bus.save_unf   = unf_q;
  assign bus.save_depth = depth_q;

endmodule

// File: tb/tb_isp8_flags.sv
// Directed bench for isp8_flags: a vector table for the flag-update priority
// rules plus hand-written sequences for save/restore, stack limits and reset.
module tb_isp8_flags;

`ifdef ISP8_FLAG_NEST_EN
  localparam int Cap = 4;
`else
  localparam int Cap = 1;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  isp8_flags_if bus ();

  isp8_flags #(.NEST_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {upd_c, upd_z, setc, clrc, setz, clrz, seti, clri}; exp = {C, Z, I, cond_true}
  typedef struct {
    logic [7:0] ctl;
    logic [7:0] dout;
    logic       cout;
    logic [1:0] cond;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.dout_alu  = 8'h55;
    bus.cout_alu  = 1'b0;
    {bus.upd_c, bus.upd_z, bus.setc, bus.clrc, bus.setz, bus.clrz, bus.seti, bus.clri} = 8'h00;
    bus.int_entry = 1'b0;
    bus.reti      = 1'b0;
    bus.cond      = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic c, input logic z, input logic i);
    chk({name, ".C"}, 4'(bus.carry_flag), 4'(c));
    chk({name, ".Z"}, 4'(bus.zero_flag), 4'(z));
    chk({name, ".I"}, 4'(bus.ie_flag), 4'(i));
  endtask

  initial begin
    logic [1:0] pats [5];
    logic [1:0] p;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clear_inputs();
    #2;
    chk_flags("async_reset", 1'b0, 1'b0, 1'b0);
    chk("async_reset.depth", bus.save_depth, 4'd0);
    do_reset();

    // Reset state
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.depth", bus.save_depth, 4'd0);
    chk("reset.ovf", 4'(bus.save_ovf), 4'd0);
    chk("reset.unf", 4'(bus.save_unf), 4'd0);
    chk("reset.cond00", 4'(bus.cond_true), 4'd0);

    // Priority table
    vecs[0] = '{8'b1100_0000, 8'h00, 1'b1, 2'b00, 4'b1101};
    vecs[1] = '{8'b0000_0000, 8'h00, 1'b0, 2'b11, 4'b1100};
    vecs[2] = '{8'b1111_0100, 8'h00, 1'b0, 2'b10, 4'b1001};
    vecs[3] = '{8'b1100_1000, 8'h05, 1'b0, 2'b01, 4'b0100};
    vecs[4] = '{8'b0101_0000, 8'h80, 1'b0, 2'b00, 4'b0000};
    vecs[5] = '{8'b0000_0011, 8'h00, 1'b0, 2'b11, 4'b0011};
    vecs[6] = '{8'b1000_0001, 8'h00, 1'b1, 2'b10, 4'b1001};
    vecs[7] = '{8'b0110_0000, 8'h00, 1'b0, 2'b01, 4'b1100};
    vecs[8] = '{8'b1101_1000, 8'h07, 1'b1, 2'b10, 4'b0100};
    vecs[9] = '{8'b1000_0010, 8'h00, 1'b1, 2'b00, 4'b1111};
    for (int n = 0; n < 10; n++) begin
      {bus.upd_c, bus.upd_z, bus.setc, bus.clrc, bus.setz, bus.clrz, bus.seti, bus.clri} =
        vecs[n].ctl;
      bus.dout_alu = vecs[n].dout;
      bus.cout_alu = vecs[n].cout;
      bus.cond     = vecs[n].cond;
      // Flags must not move before the edge.
      if (n == 0) chk("vec0.before_edge", 4'(bus.carry_flag), 4'd0);
      tick();
      chk($sformatf("vec%0d.C", n), 4'(bus.carry_flag), 4'(vecs[n].exp[3]));
      chk($sformatf("vec%0d.Z", n), 4'(bus.zero_flag), 4'(vecs[n].exp[2]));
      chk($sformatf("vec%0d.I", n), 4'(bus.ie_flag), 4'(vecs[n].exp[1]));
      chk($sformatf("vec%0d.cond", n), 4'(bus.cond_true), 4'(vecs[n].exp[0]));
    end
    clear_inputs();

    // Save then restore a single frame
    do_reset();
    bus.seti = 1'b1; bus.setc = 1'b1; bus.clrz = 1'b1;
    tick();
    clear_inputs();
    chk_flags("frame.pre", 1'b1, 1'b0, 1'b1);
    bus.int_entry = 1'b1;
    tick();
    clear_inputs();
    chk_flags("frame.entry", 1'b1, 1'b0, 1'b0);
    chk("frame.entry.depth", bus.save_depth, 4'd1);
    bus.clrc = 1'b1; bus.setz = 1'b1;
    tick();
    clear_inputs();
    chk_flags("frame.body", 1'b0, 1'b1, 1'b0);
    bus.reti = 1'b1;
    tick();
    clear_inputs();
    chk_flags("frame.reti", 1'b1, 1'b0, 1'b1);
    chk("frame.reti.depth", bus.save_depth, 4'd0);

    // Underflow is sticky and leaves flags alone
    bus.reti = 1'b1;
    tick();
    clear_inputs();
    chk_flags("unf", 1'b1, 1'b0, 1'b1);
    chk("unf.set", 4'(bus.save_unf), 4'd1);
    chk("unf.depth", bus.save_depth, 4'd0);
    for (int n = 0; n < 10; n++) tick();
    chk("unf.sticky", 4'(bus.save_unf), 4'd1);
    chk("unf.no_ovf", 4'(bus.save_ovf), 4'd0);

    // Fill past capacity, then unwind in LIFO order
    do_reset();
    for (int k = 0; k < 5; k++) begin
      p = k[1:0];
      pats[k] = p;
      bus.seti = 1'b1;
      bus.setc = p[1]; bus.clrc = ~p[1];
      bus.setz = p[0]; bus.clrz = ~p[0];
      tick();
      clear_inputs();
      bus.int_entry = 1'b1;
      tick();
      clear_inputs();
      chk_flags($sformatf("push%0d", k), p[1], p[0], 1'b0);
      chk($sformatf("push%0d.depth", k), bus.save_depth, 4'((k + 1 > Cap) ? Cap : k + 1));
      chk($sformatf("push%0d.ovf", k), 4'(bus.save_ovf), 4'((k + 1 > Cap) ? 1 : 0));
    end
    for (int j = 0; j < Cap; j++) begin
      bus.reti = 1'b1;
      tick();
      clear_inputs();
      p = pats[Cap - 1 - j];
      chk_flags($sformatf("pop%0d", j), p[1], p[0], 1'b1);
      chk($sformatf("pop%0d.depth", j), bus.save_depth, 4'(Cap - 1 - j));
    end
    chk("pops.no_unf", 4'(bus.save_unf), 4'd0);

    // Simultaneous entry/return, then reset in the middle of a cycle
    do_reset();
    bus.setc = 1'b1; bus.setz = 1'b1; bus.seti = 1'b1;
    tick();
    clear_inputs();
    bus.int_entry = 1'b1;
    tick();
    clear_inputs();
    bus.int_entry = 1'b1; bus.reti = 1'b1;
    tick();
    clear_inputs();
    chk("both.depth", bus.save_depth, 4'((Cap > 1) ? 2 : 1));
    chk("both.unf", 4'(bus.save_unf), 4'd0);
    chk("both.ovf", 4'(bus.save_ovf), 4'((Cap > 1) ? 0 : 1));
    chk_flags("both", 1'b1, 1'b1, 1'b0);
    bus.cond = 2'b01;
    bus.reti = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk_flags("midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst.depth", bus.save_depth, 4'd0);
    chk("midrst.ovf", 4'(bus.save_ovf), 4'd0);
    chk("midrst.unf", 4'(bus.save_unf), 4'd0);
    chk("midrst.cond01", 4'(bus.cond_true), 4'd1);
    bus.cond = 2'b10;
    #1;
    chk("midrst.cond10", 4'(bus.cond_true), 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // First edge after reset sees an empty stack
    tick();
    clear_inputs();
    chk("postrst.unf", 4'(bus.save_unf), 4'd1);
    chk_flags("postrst", 1'b0, 1'b0, 1'b0);
    chk("postrst.depth", bus.save_depth, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isp8_flags.md
ISP8_FLAGS -- requirements
Module: isp8_flags

Interface
REQ-001 SHALL provide parameter NEST_DEPTH, default 4, save-stack depth (2..8) used only when ISP8_FLAG_NEST_EN is defined.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port dout_alu  input  8  ALU result, source of zero flag.
REQ-005 SHALL have port cout_alu  input  1  ALU carry/borrow out.
REQ-006 SHALL have port upd_c / upd_z  input  1 each  load carry / zero from ALU this cycle.
REQ-007 SHALL have port setc, clrc, setz, clrz, seti, clri  input  1 each  explicit flag set/clear.
REQ-008 SHALL have port int_entry  input  1  one-cycle pulse, interrupt accepted; save flags.
REQ-009 SHALL have port reti  input  1  one-cycle pulse, return from interrupt; restore flags.
REQ-010 SHALL have port cond  input  2  branch condition: 00 Z, 01 NZ, 10 C, 11 NC.
REQ-011 SHALL have port carry_flag, zero_flag, ie_flag  output  1 each  registered flags.
REQ-012 SHALL have port cond_true  output  1  combinational condition result.
REQ-013 SHALL have port save_ovf, save_unf  output  1 each  sticky save overflow / restore underflow.
REQ-014 SHALL have port save_depth  output  4  number of valid saved entries.

Function
REQ-015 SHALL compute zero candidate as (dout_alu == 8'h00); carry candidate is cout_alu unmodified.
REQ-016 SHALL make every flag update visible on outputs exactly one clk after the qualifying input cycle.
REQ-017 SHALL apply per-cycle priority: int_entry > reti > set/clr > upd_c/upd_z > hold.
REQ-018 SHALL, when both set and clear of one flag assert, let set win; set/clr of one flag does not block upd of another.
REQ-019 SHALL on int_entry push {ie_flag, zero_flag, carry_flag}, increment save_depth, clear ie_flag, leave C and Z unchanged.
REQ-020 SHALL on reti (without int_entry) pop the top entry into {ie, Z, C} and decrement save_depth.
REQ-021 SHALL ignore reti when int_entry asserts in the same cycle (no pop, no unf).
REQ-022 SHALL on reti with save_depth 0 leave all flags unchanged and set save_unf.
REQ-023 SHALL on int_entry with stack full leave stack contents and save_depth unchanged, still clear ie_flag, and set save_ovf.
REQ-024 SHALL keep save_ovf/save_unf set until reset.
REQ-025 SHALL drive cond_true from registered flags only: Z, ~Z, C, ~C per cond.
REQ-026 SHALL treat stack as LIFO; pop returns most recent push.

Reset
REQ-027 SHALL on rst asynchronously clear carry_flag, zero_flag, ie_flag, save_depth, save_ovf, save_unf and all stack entries.
REQ-028 SHALL abort any in-progress save/restore on rst mid-cycle; first post-reset edge sees empty stack.
REQ-029 SHALL drive cond_true = 0 for cond=00/10 and 1 for cond=01/11 while in reset.

Configuration
REQ-030 SHALL, with ISP8_FLAG_NEST_EN defined, implement NEST_DEPTH-entry save stack (full at save_depth == NEST_DEPTH).
REQ-031 SHALL, without ISP8_FLAG_NEST_EN, implement single save register (full at save_depth == 1); NEST_DEPTH ignored; all other behaviour identical.

Verification
REQ-032 SHALL cover: dout_alu=8'h00, cout_alu=1, upd_c=upd_z=1 -> next cycle C=1, Z=1; cond=00 -> cond_true=1, cond=11 -> 0.
REQ-033 SHALL cover: setc=clrc=1 with upd_c=1, cout_alu=0 -> C=1; clrz=1, upd_z=1, dout_alu=0 -> Z=0.
REQ-034 SHALL cover: seti; C=1,Z=0; int_entry -> ie=0, depth=1; clrc, setz; reti -> ie=1, C=1, Z=0, depth=0.
REQ-035 SHALL cover: reti at depth 0 -> flags unchanged, save_unf=1 and remains 1 after 10 idle cycles.
REQ-036 SHALL cover: NEST_EN, NEST_DEPTH=4, five int_entry with distinct C/Z -> depth=4, save_ovf=1; four reti restore in reverse order of first four pushes (without macro: second int_entry sets save_ovf, reti restores first).
REQ-037 SHALL cover: int_entry and reti same cycle at depth 1 -> depth=2, no save_unf; rst asserted mid-cycle -> all outputs 0 immediately.
